// File: rtl/sprite_pkg.sv
// Shared sprite definitions: ROM geometry, enemy sprite ids, reader FSM states.
package sprite_pkg;

  localparam int SPRITE_W    = 8;
  localparam int SPRITE_ROWS = 8;

  typedef enum logic [2:0] {
    ENEMY_A0 = 3'd0,
    ENEMY_A1 = 3'd1,
    ENEMY_B0 = 3'd2,
    ENEMY_B1 = 3'd3,
    ENEMY_C0 = 3'd4,
    ENEMY_C1 = 3'd5
  } sprite_id_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_t;

  function automatic logic [SPRITE_W-1:0] reverse_byte(input logic [SPRITE_W-1:0] b);
    logic [SPRITE_W-1:0] r;
    for (int i = 0; i < SPRITE_W; i++) r[i] = b[SPRITE_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sprite_row_reader.sv
// Fetches one sprite row from the external combinational ROM and streams it as
// SCALE-repeated pixels. Optional mirroring under SPRITE_ROW_READER_MIRROR_EN.
module sprite_row_reader
  import sprite_pkg::*;
#(
  parameter int SCALE       = 2,
  parameter int NUM_SPRITES = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sprite,
  input  logic [2:0] req_row,
`ifdef SPRITE_ROW_READER_MIRROR_EN
  input  logic       req_mirror,
`endif
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_on,
  output logic       pix_last
);

  localparam logic [1:0] REP_MAX = 2'(SCALE - 1);

  state_t              state;
  logic                oor;
  logic [SPRITE_W-1:0] shreg;
  logic [2:0]          bit_cnt;
  logic [1:0]          rep;
  logic [SPRITE_W-1:0] fetch_data;

`ifdef SPRITE_ROW_READER_MIRROR_EN
  logic mirror;

  always_comb begin
    fetch_data = mirror ? reverse_byte(rom_data) : rom_data;
  end
`else
  always_comb begin
    fetch_data = rom_data;
  end
`endif

  assign pix_on   = pix_valid & shreg[SPRITE_W-1];
  assign pix_last = pix_valid && (bit_cnt == 3'd7) && (rep == REP_MAX);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would create order-dependent logic.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rom_addr  <= '0;
      pix_valid <= 1'b0;
      oor       <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      rep       <= '0;
`ifdef SPRITE_ROW_READER_MIRROR_EN
      mirror    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rom_addr  <= {2'b00, req_sprite, req_row};
            oor       <= (int'(req_sprite) >= NUM_SPRITES);
`ifdef SPRITE_ROW_READER_MIRROR_EN
            mirror    <= req_mirror;
`endif
            req_ready <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Out-of-range ids stream a blank row; rom_data is ignored.
          shreg     <= oor ? '0 : fetch_data;
          bit_cnt   <= '0;
          rep       <= '0;
          pix_valid <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            if (rep == REP_MAX) begin
              rep     <= '0;
              shreg   <= {shreg[SPRITE_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              rep <= rep + 2'd1;
            end
            if (pix_last) begin
              pix_valid <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_reader.sv
// Self-checking bench for sprite_row_reader: behavioural ROM plus a pixel-queue
// reference model; honours SPRITE_ROW_READER_MIRROR_EN when defined.
module tb_sprite_row_reader;

  localparam int SCALE       = 2;
  localparam int NUM_SPRITES = 6;
`ifdef SPRITE_ROW_READER_MIRROR_EN
  localparam bit MIRROR_ON = 1'b1;
`else
  localparam bit MIRROR_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sprite;
  logic [2:0] req_row;
  logic       req_mirror;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_on;
  logic       pix_last;

  logic [7:0] rom [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign rom_data = rom[rom_addr[5:0]];

  sprite_row_reader #(.SCALE(SCALE), .NUM_SPRITES(NUM_SPRITES)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sprite (req_sprite),
    .req_row    (req_row),
`ifdef SPRITE_ROW_READER_MIRROR_EN
    .req_mirror (req_mirror),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_on     (pix_on),
    .pix_last   (pix_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current negedge and follows the row to its end.
  // stall randomises pix_ready and injects ignored requests; abort_at >= 0
  // asserts reset while that pixel index is being presented.
  task automatic run_row(input logic [2:0] spr, input logic [2:0] row, input logic mir,
                         input bit stall, input int abort_at);
    bit         q[$];
    logic [7:0] b;
    logic [7:0] exp_addr;
    bit         out_of_range;
    int         idx;
    int         cyc;
    int         total;

    out_of_range = (int'(spr) >= NUM_SPRITES);
    exp_addr     = int'(spr) * 8 + int'(row);
    b            = rom[exp_addr[5:0]];
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < SCALE; r++)
        q.push_back(out_of_range ? 1'b0 : ((MIRROR_ON && mir) ? b[i] : b[7-i]));
    total = q.size();

    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    check("req_ready_idle", req_ready, 1);
    check("pix_valid_idle", pix_valid, 0);

    req_valid  = 1'b1;
    req_sprite = spr;
    req_row    = row;
    req_mirror = mir;
    @(negedge Clk);
    req_valid  = 1'b0;
    check("rom_addr", rom_addr, exp_addr);
    check("fetch_req_ready", req_ready, 0);
    check("fetch_pix_valid", pix_valid, 0);

    @(negedge Clk);
    check("first_pix_valid", pix_valid, 1);

    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 1000) begin
      if (idx == abort_at) begin
        Reset_n   = 1'b0;
        req_valid = 1'b0;
        pix_ready = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pix_on", pix_on, 0);
        check("rst_pix_last", pix_last, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        return;
      end
      check("pix_valid", pix_valid, 1);
      check("shift_req_ready", req_ready, 0);
      check("pix_on", pix_on, q[idx]);
      check("pix_last", pix_last, (idx == total - 1));
      pix_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      req_valid  = (stall && idx != total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_sprite = 3'($urandom);
      req_row    = 3'($urandom);
      if (pix_ready) idx++;
      @(negedge Clk);
      cyc++;
    end
    req_valid = 1'b0;
    pix_ready = 1'b0;
    check("row_complete", idx, total);
    check("ready_after_last", req_ready, 1);
    check("valid_after_last", pix_valid, 0);
    check("rom_addr_hold", rom_addr, exp_addr);
    if (!stall) check("row_cycles", cyc + 2, 8 * SCALE + 2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[3]  = 8'hFF;
    rom[19] = 8'h6A;
    rom[34] = 8'h99;

    Reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_sprite = '0;
    req_row    = '0;
    req_mirror = 1'b0;
    pix_ready  = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_pix_on", pix_on, 0);
    check("reset_pix_last", pix_last, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_row(3'd0, 3'd3, 1'b0, 1'b0, -1);
    run_row(3'd2, 3'd3, 1'b0, 1'b0, -1);
    run_row(3'd4, 3'd2, 1'b0, 1'b1, -1);
    run_row(3'd6, 3'd0, 1'b0, 1'b0, -1);
    run_row(3'd7, 3'd5, 1'b0, 1'b1, -1);
    run_row(3'd2, 3'd3, 1'b1, 1'b0, -1);
    run_row(3'd1, 3'd4, 1'b0, 1'b0, 2);
    run_row(3'd1, 3'd4, 1'b0, 1'b0, -1);
    for (int n = 0; n < 12; n++)
      run_row(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
